// File: rtl/lisnoc_dma_target_r2l_resp_pkg.sv
// ---------------------------------------------------------------------------
// lisnoc_dma_target_r2l_resp_pkg
//
// Shared LISNoC / DMA definitions used by the R2L response engine:
//   - flit type codes (top two bits of every flit)
//   - header field positions (destination, packet type, response-last, id)
//   - R2L_RESP packet type code and destination width
//   - FSM state encoding of the response engine
//   - helper that assembles the 32-bit header content
// ---------------------------------------------------------------------------
package lisnoc_dma_target_r2l_resp_pkg;

    // A flit is {type[1:0], content[31:0]}
    localparam int FLIT_WIDTH = 34;

    localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;

    // Header content layout
    localparam int DEST_WIDTH       = 5;
    localparam int DEST_LSB         = 27;   // dest occupies [31:27]
    localparam int PACKET_TYPE_LSB  = 18;   // packet type occupies [19:18]
    localparam int PACKET_RESP_LAST = 16;
    localparam int PACKET_ID_MSB    = 15;
    localparam int PACKET_ID_LSB    = 14;

    localparam logic [1:0] PACKET_TYPE_R2L_RESP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_DATA
    } r2l_state_e;

    function automatic logic [31:0] r2l_header(
        input logic [DEST_WIDTH-1:0]                dest,
        input logic [PACKET_ID_MSB-PACKET_ID_LSB:0] id,
        input logic                                 resp_last
    );
        logic [31:0] c;
        c = '0;
        c[DEST_LSB +: DEST_WIDTH]    = dest;
        c[PACKET_TYPE_LSB +: 2]      = PACKET_TYPE_R2L_RESP;
        c[PACKET_RESP_LAST]          = resp_last;
        c[PACKET_ID_MSB:PACKET_ID_LSB] = id;
        return c;
    endfunction

endpackage

// File: rtl/lisnoc_fifo.sv
// ---------------------------------------------------------------------------
// lisnoc_fifo
//
// Small synchronous FIFO with valid/ready on both sides. A push and a pop in
// the same cycle leave the occupancy unchanged.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset (empties the FIFO)
//   in_flit/in_valid  write data / write request
//   in_ready          FIFO not full
//   out_flit          head entry
//   out_valid         FIFO not empty
//   out_ready         consumer takes the head entry
// ---------------------------------------------------------------------------
module lisnoc_fifo #(
    parameter int flit_width = 32,
    parameter int LENGTH     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [flit_width-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [flit_width-1:0] out_flit,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int CW = $clog2(LENGTH + 1);

    logic [flit_width-1:0] mem [LENGTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(LENGTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count != CW'(LENGTH));
    assign out_valid = (count != '0);
    assign out_flit  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is not reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_flit;
    end

endmodule

// File: rtl/lisnoc_dma_target_r2l_resp.sv
// ---------------------------------------------------------------------------
// lisnoc_dma_target_r2l_resp
//
// Responder side of a LISNoC DMA remote-to-local transfer. Accepts one R2L
// read request, reads the words from local memory over Wishbone and sends
// them as R2L_RESP packets: header, remote-address flit, data flits. Long
// transfers are split into packets of at most noc_packet_size-2 data words;
// only the final packet carries RESP_LAST.
//
// Build option: define LISNOC_DMA_TARGET_WB_BURST_EN to issue incrementing
// bursts (cti 010, 111 on the last word of each packet); otherwise classic
// cycles (cti 000) are used.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   req_*                    request handshake and decoded request fields
//   noc_out_flit/valid/ready outgoing NoC flit stream
//   wb_*                     Wishbone read master
//   busy                     transfer in progress
// ---------------------------------------------------------------------------
module lisnoc_dma_target_r2l_resp
    import lisnoc_dma_target_r2l_resp_pkg::*;
#(
    parameter int flit_width             = FLIT_WIDTH,
    parameter int noc_packet_size        = 16,
    parameter int table_entries_ptrwidth = 2
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [table_entries_ptrwidth-1:0] req_id,
    input  logic [DEST_WIDTH-1:0]             req_dest,
    input  logic [31:0]                       req_laddr,
    input  logic [31:0]                       req_raddr,
    input  logic [15:0]                       req_size,

    output logic [flit_width-1:0]             noc_out_flit,
    output logic                              noc_out_valid,
    input  logic                              noc_out_ready,

    output logic                              wb_cyc_o,
    output logic                              wb_stb_o,
    output logic                              wb_we_o,
    output logic [31:0]                       wb_adr_o,
    input  logic [31:0]                       wb_dat_i,
    input  logic                              wb_ack_i,
    output logic [2:0]                        wb_cti_o,
    output logic [1:0]                        wb_bte_o,
    output logic [3:0]                        wb_sel_o,

    output logic                              busy
);

    localparam logic [15:0] MAX_PW = 16'(noc_packet_size - 2);

    r2l_state_e                        state;
    logic [table_entries_ptrwidth-1:0] id_q;
    logic [DEST_WIDTH-1:0]             dest_q;
    logic [31:0]                       laddr_q;
    logic [31:0]                       raddr_q;
    logic [15:0]                       remaining;
    logic [15:0]                       issued;    // words acked in this packet
    logic [15:0]                       emitted;   // data flits sent in this packet

    logic [15:0] pw;
    logic        pkt_last;
    logic        data_last;

    logic        fifo_in_ready;
    logic        fifo_push;
    logic [31:0] fifo_dout;
    logic        fifo_out_valid;
    logic        fifo_out_ready;

    logic [1:0]  out_type;
    logic [31:0] out_content;

    assign pw        = (remaining < MAX_PW) ? remaining : MAX_PW;
    assign pkt_last  = (remaining <= MAX_PW);
    assign data_last = (emitted == pw - 16'd1);

    assign req_ready = rst & (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Read engine: keep requesting while words remain and there is room
    // for the answer; stb can only fall on an ack, so adr stays stable.
    assign wb_stb_o  = (state == ST_DATA) && (issued < pw) && fifo_in_ready;
    assign wb_cyc_o  = wb_stb_o;
    assign wb_we_o   = 1'b0;
    assign wb_adr_o  = laddr_q;
    assign wb_bte_o  = 2'b00;
    assign wb_sel_o  = 4'hf;
    assign fifo_push = wb_stb_o & wb_ack_i;

`ifdef LISNOC_DMA_TARGET_WB_BURST_EN
    assign wb_cti_o = !wb_stb_o               ? 3'b000 :
                      (issued == pw - 16'd1)  ? 3'b111 : 3'b010;
`else
    assign wb_cti_o = 3'b000;
`endif

    lisnoc_fifo #(
        .flit_width (32),
        .LENGTH     (2)
    ) u_data_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (wb_dat_i),
        .in_valid  (fifo_push),
        .in_ready  (fifo_in_ready),
        .out_flit  (fifo_dout),
        .out_valid (fifo_out_valid),
        .out_ready (fifo_out_ready)
    );

    assign fifo_out_ready = (state == ST_DATA) & noc_out_ready;

    // Flit emitter: everything is decoded from registered state or the FIFO
    // head, so the flit is stable while waiting for noc_out_ready.
    always_comb begin
        out_type      = FLIT_TYPE_PAYLOAD;
        out_content   = '0;
        noc_out_valid = 1'b0;
        case (state)
            ST_HDR: begin
                noc_out_valid = 1'b1;
                out_type      = FLIT_TYPE_HEADER;
                out_content   = r2l_header(dest_q, id_q, pkt_last);
            end
            ST_ADDR: begin
                noc_out_valid = 1'b1;
                out_type      = (pw == '0) ? FLIT_TYPE_LAST : FLIT_TYPE_PAYLOAD;
                out_content   = raddr_q;
            end
            ST_DATA: begin
                noc_out_valid = fifo_out_valid;
                out_type      = data_last ? FLIT_TYPE_LAST : FLIT_TYPE_PAYLOAD;
                out_content   = fifo_dout;
            end
            default: ;
        endcase
    end

    assign noc_out_flit = flit_width'({out_type, out_content});

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            issued    <= '0;
            emitted   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        id_q      <= req_id;
                        dest_q    <= req_dest;
                        laddr_q   <= req_laddr;
                        raddr_q   <= req_raddr;
                        remaining <= req_size;
                        issued    <= '0;
                        emitted   <= '0;
                        state     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (noc_out_ready) state <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (noc_out_ready) state <= (pw == '0) ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (fifo_push) begin
                        issued  <= issued + 16'd1;
                        laddr_q <= laddr_q + 32'd4;
                    end
                    // All words are acked before the LAST flit leaves,
                    // so resetting issued here cannot drop an ack.
                    if (fifo_out_valid && noc_out_ready) begin
                        if (data_last) begin
                            emitted   <= '0;
                            issued    <= '0;
                            remaining <= remaining - pw;
                            raddr_q   <= raddr_q + {14'd0, pw, 2'b00};
                            state     <= pkt_last ? ST_IDLE : ST_HDR;
                        end else begin
                            emitted <= emitted + 16'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lisnoc_dma_target_r2l_resp.sv
module tb_lisnoc_dma_target_r2l_resp;

    localparam int PW_MAX = 14;   // data words per packet (16 - header - address)

`ifdef LISNOC_DMA_TARGET_WB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_id = '0;
    logic [4:0]  req_dest = '0;
    logic [31:0] req_laddr = '0;
    logic [31:0] req_raddr = '0;
    logic [15:0] req_size = '0;
    logic [33:0] noc_out_flit;
    logic        noc_out_valid;
    logic        noc_out_ready;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [3:0]  wb_sel_o;
    logic        busy;

    always #5 clk = ~clk;

    lisnoc_dma_target_r2l_resp dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_id        (req_id),
        .req_dest      (req_dest),
        .req_laddr     (req_laddr),
        .req_raddr     (req_raddr),
        .req_size      (req_size),
        .noc_out_flit  (noc_out_flit),
        .noc_out_valid (noc_out_valid),
        .noc_out_ready (noc_out_ready),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_we_o       (wb_we_o),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_i      (wb_dat_i),
        .wb_ack_i      (wb_ack_i),
        .wb_cti_o      (wb_cti_o),
        .wb_bte_o      (wb_bte_o),
        .wb_sel_o      (wb_sel_o),
        .busy          (busy)
    );

    typedef struct {
        logic [33:0] flit;
        bit          final_flit;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] cti_q[$];

    int tests = 0;
    int fails = 0;
    int pops = 0;
    int acks = 0;
    int cyc_cycles = 0;

    bit ready_force_low = 1'b0;
    bit ready_rand      = 1'b0;
    bit ack_rand        = 1'b0;
    int ack_delay       = 0;
    int wait_cnt        = 0;
    int cur_delay       = 0;

    // Local memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [33:0] hdr_flit(input logic [4:0] dest, input logic [1:0] id,
                                             input bit last);
        logic [31:0] c;
        c = '0;
        c[31:27] = dest;
        c[19:18] = 2'b11;
        c[16]    = last;
        c[15:14] = id;
        return {2'b01, c};
    endfunction

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: whole transfer broken into packets by plain arithmetic
    task automatic expect_transfer(input logic [1:0] id, input logic [4:0] dest,
                                   input logic [31:0] la, input logic [31:0] ra,
                                   input int size);
        int   rem;
        int   off;
        int   pw;
        bit   last;
        exp_t e;
        rem = size;
        off = 0;
        do begin
            pw   = (rem < PW_MAX) ? rem : PW_MAX;
            last = (rem <= PW_MAX);
            e.flit = hdr_flit(dest, id, last);
            e.final_flit = 1'b0;
            exp_q.push_back(e);
            e.flit = {(pw == 0) ? 2'b10 : 2'b00, ra + 32'(4 * off)};
            e.final_flit = (pw == 0);
            exp_q.push_back(e);
            for (int i = 0; i < pw; i++) begin
                e.flit = {(i == pw - 1) ? 2'b10 : 2'b00, mem_word(la + 32'(4 * (off + i)))};
                e.final_flit = last && (i == pw - 1);
                exp_q.push_back(e);
                cti_q.push_back(BURST ? ((i == pw - 1) ? 3'b111 : 3'b010) : 3'b000);
            end
            off += pw;
            rem -= pw;
        end while (rem > 0);
    endtask

    // Called and returns just after a rising edge
    task automatic send_req(input logic [1:0] id, input logic [4:0] dest,
                            input logic [31:0] la, input logic [31:0] ra, input int size);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            check(1'b0, "req_ready_timeout", 64'(req_ready), 64'd1);
            return;
        end
        req_valid = 1'b1;
        req_id    = id;
        req_dest  = dest;
        req_laddr = la;
        req_raddr = ra;
        req_size  = 16'(size);
        expect_transfer(id, dest, la, ra, size);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check(noc_out_valid && noc_out_flit == hdr_flit(dest, id, size <= PW_MAX),
              "hdr_next_cycle", {29'd0, noc_out_valid, noc_out_flit},
              {29'd0, 1'b1, hdr_flit(dest, id, size <= PW_MAX)});
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(exp_q.size() == 0, "drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        check(busy == 1'b0, "busy_after_last", 64'(busy), 64'd0);
        check(req_ready == 1'b1, "ready_after_last", 64'(req_ready), 64'd1);
    endtask

    // NoC sink
    initial begin
        noc_out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ready_force_low)  noc_out_ready = 1'b0;
            else if (ready_rand)  noc_out_ready = ($urandom_range(0, 3) != 0);
            else                  noc_out_ready = 1'b1;
        end
    end

    // Wishbone slave with configurable wait states
    initial begin
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(posedge clk); #1;
            if (rst && wb_stb_o) begin
                if (wait_cnt >= cur_delay) begin
                    wb_ack_i  = 1'b1;
                    wb_dat_i  = mem_word(wb_adr_o);
                    wait_cnt  = 0;
                    cur_delay = ack_rand ? int'($urandom_range(0, 2)) : ack_delay;
                end else begin
                    wb_ack_i = 1'b0;
                    wb_dat_i = $urandom;
                    wait_cnt++;
                end
            end else begin
                wb_ack_i  = 1'b0;
                wait_cnt  = 0;
                cur_delay = ack_rand ? int'($urandom_range(0, 2)) : ack_delay;
            end
        end
    end

    // Scoreboard monitor and handshake-stability checks
    logic [33:0] prev_flit;
    logic [31:0] prev_adr;
    bit          prev_hold = 1'b0;
    bit          prev_wait = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
            prev_wait = 1'b0;
        end else begin
            if (prev_hold)
                check(noc_out_valid && noc_out_flit == prev_flit, "flit_hold",
                      64'(noc_out_flit), 64'(prev_flit));
            if (prev_wait)
                check(wb_stb_o && wb_cyc_o && wb_adr_o == prev_adr, "wb_hold",
                      {31'd0, wb_stb_o, wb_adr_o}, {31'd0, 1'b1, prev_adr});
            if (!wb_stb_o && prev_wait == 1'b0 && wb_cti_o != 3'b000)
                check(1'b0, "cti_idle", 64'(wb_cti_o), 64'd0);
            if (wb_cyc_o) cyc_cycles++;
            if (wb_stb_o && wb_ack_i) begin
                acks++;
                if (cti_q.size() == 0)
                    check(1'b0, "unexpected_ack", 64'(wb_adr_o), 64'd0);
                else begin
                    logic [2:0] ec;
                    ec = cti_q.pop_front();
                    check(wb_cti_o == ec, "cti", 64'(wb_cti_o), 64'(ec));
                end
            end
            if (noc_out_valid && noc_out_ready) begin
                pops++;
                if (exp_q.size() == 0)
                    check(1'b0, "unexpected_flit", 64'(noc_out_flit), 64'd0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(noc_out_flit == e.flit, "flit", 64'(noc_out_flit), 64'(e.flit));
                    if (e.final_flit)
                        check(busy == 1'b1, "busy_at_last", 64'(busy), 64'd1);
                end
            end
            prev_hold = noc_out_valid && !noc_out_ready;
            prev_flit = noc_out_flit;
            prev_wait = wb_stb_o && !wb_ack_i;
            prev_adr  = wb_adr_o;
        end
    end

    initial begin
        int base;
        int n;
        int c0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(req_ready == 1'b0, "rst_req_ready", 64'(req_ready), 64'd0);
        check(noc_out_valid == 1'b0, "rst_valid", 64'(noc_out_valid), 64'd0);
        check(wb_cyc_o == 1'b0 && wb_stb_o == 1'b0, "rst_cyc_stb", {wb_cyc_o, wb_stb_o}, 64'd0);
        check(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        #1;
        check(req_ready == 1'b1, "ready_after_rst", 64'(req_ready), 64'd1);
        check(wb_we_o == 1'b0 && wb_sel_o == 4'hf && wb_bte_o == 2'b00, "wb_constants",
              {wb_we_o, wb_sel_o, wb_bte_o}, {1'b0, 4'hf, 2'b00});

        // Basic 3-word transfer
        send_req(2'd2, 5'd5, 32'h100, 32'h2000, 3);
        wait_done(200);

        // Three packets: 14 / 14 / 2
        send_req(2'd1, 5'd9, 32'h1000, 32'h2000, 30);
        wait_done(400);

        // Back-pressure mid-packet
        base = pops;
        send_req(2'd3, 5'd17, 32'h400, 32'h3000, 14);
        n = 0;
        while (pops < base + 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(pops >= base + 5, "bp_start_timeout", 64'(pops - base), 64'd5);
        ready_force_low = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        check(wb_stb_o == 1'b0 && wb_cyc_o == 1'b0, "bp_stb_drop",
              {wb_cyc_o, wb_stb_o}, 64'd0);
        check(noc_out_valid == 1'b1, "bp_valid_held", 64'(noc_out_valid), 64'd1);
        ready_force_low = 1'b0;
        wait_done(400);

        // Slow memory
        ack_delay = 3;
        send_req(2'd0, 5'd1, 32'h800, 32'h5000, 5);
        wait_done(400);
        ack_delay = 0;

        // Zero-length transfer: no Wishbone activity
        c0 = cyc_cycles;
        send_req(2'd1, 5'd2, 32'h900, 32'h6000, 0);
        wait_done(100);
        check(cyc_cycles == c0, "size0_no_cyc", 64'(cyc_cycles - c0), 64'd0);

        // Reset during word 5 of a 14-word packet
        base = acks;
        send_req(2'd1, 5'd3, 32'hA00, 32'h4000, 14);
        n = 0;
        while (acks < base + 4 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check(acks >= base + 4, "rst_mid_timeout", 64'(acks - base), 64'd4);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check(wb_cyc_o == 1'b0 && wb_stb_o == 1'b0, "midrst_cyc_stb", {wb_cyc_o, wb_stb_o}, 64'd0);
        check(noc_out_valid == 1'b0, "midrst_valid", 64'(noc_out_valid), 64'd0);
        check(busy == 1'b0, "midrst_busy", 64'(busy), 64'd0);
        check(req_ready == 1'b0, "midrst_req_ready", 64'(req_ready), 64'd0);
        exp_q.delete();
        cti_q.delete();
        rst = 1'b1;
        #1;
        check(req_ready == 1'b1, "ready_after_midrst", 64'(req_ready), 64'd1);
        base = pops;
        send_req(2'd2, 5'd6, 32'hB00, 32'h7000, 1);
        wait_done(100);
        check(pops - base == 3, "post_rst_flit_count", 64'(pops - base), 64'd3);

        // Randomized transfers with random back-pressure and wait states
        ready_rand = 1'b1;
        ack_rand   = 1'b1;
        for (int t = 0; t < 12; t++) begin
            logic [31:0] la;
            logic [31:0] ra;
            la = (t % 4 == 0) ? 32'hFFFF_FFE0 : ($urandom & 32'hFFFF_FFFC);
            ra = (t % 4 == 1) ? 32'hFFFF_FFC8 : ($urandom & 32'hFFFF_FFFC);
            send_req(2'($urandom), 5'($urandom), la, ra, int'($urandom_range(0, 40)));
            wait_done(2000);
        end
        ready_rand = 1'b0;
        ack_rand   = 1'b0;

        repeat (5) @(negedge clk);
        check(exp_q.size() == 0 && cti_q.size() == 0, "queues_empty",
              64'(exp_q.size() + cti_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lisnoc_dma_target_r2l_resp.md
# lisnoc_dma_target_r2l_resp

Responder-side engine of the LISNoC DMA remote-to-local (R2L) transfer. It accepts one decoded R2L read request at a time, fetches the requested words from local memory over a Wishbone master port, and emits them as R2L_RESP packets on the NoC. These packets are consumed by the initiator's NoC response handler: header, remote-address flit, then data flits. Transfers longer than one packet are split automatically, and the final packet carries the response-last flag.

## Interface
- flit_width, `FLIT_WIDTH, NoC flit width (type bits + 32-bit content)
- noc_packet_size, 16, maximum flits per packet (header + address + data)
- table_entries_ptrwidth, 2, width of request id
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_id  in  table_entries_ptrwidth  initiator table id, echoed in PACKET_ID
- req_dest  in  `DEST_WIDTH  NoC destination (requesting tile)
- req_laddr  in  32  local read start address (word aligned)
- req_raddr  in  32  remote write start address (word aligned)
- req_size  in  16  transfer length in 32-bit words
- noc_out_flit  out  flit_width  outgoing flit
- noc_out_valid  out  1  flit valid
- noc_out_ready  in  1  NoC accepts flit
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle/strobe
- wb_we_o  out  1  constant 0
- wb_adr_o  out  32  read address
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge
- wb_cti_o  out  3  cycle type
- wb_bte_o  out  2  constant 2'b00
- wb_sel_o  out  4  constant 4'hf
- busy  out  1  high from request acceptance until final flit is accepted

## Operation
- States: IDLE, HDR, ADDR, DATA.
- IDLE: req_ready=1. On handshake, latch id, dest, laddr, raddr, and remaining=req_size; go to HDR.
- Packet data words: pw = min(remaining, noc_packet_size-2). Packet last = (remaining <= noc_packet_size-2).
- HDR: drive header flit: FLIT_TYPE_HEADER, dest field=req_dest, PACKET_TYPE=`PACKET_TYPE_R2L_RESP, PACKET_ID=id, PACKET_RESP_LAST=packet last. On noc_out_ready, go to ADDR.
- ADDR: content = current raddr. If pw=0, the type is LAST and the next state is IDLE. Otherwise the type is PAYLOAD and the next state is DATA.
- DATA: read engine and flit emitter run concurrently through a 2-entry data FIFO.
  - Read engine: wb_cyc_o=wb_stb_o=1 while words issued < pw and FIFO not full. On wb_ack_i, push wb_dat_i and add 4 to laddr.
  - Emitter: noc_out_valid = FIFO not empty. The last data flit of the packet is typed LAST; all others are PAYLOAD.
  - After the LAST flit is accepted: remaining -= pw and raddr += 4*pw. Go to HDR if remaining>0, else IDLE.
- req_size=0 produces header (RESP_LAST=1) and an address flit typed LAST, with no Wishbone cycle.
- Simultaneous FIFO push and pop keeps the count unchanged.
- laddr/raddr wrap modulo 2^32.

## Timing
- Reset values (rst=0 at a clock edge): state IDLE, noc_out_valid 0, wb_cyc_o/wb_stb_o 0, busy 0, req_ready 0 while rst=0, FIFO empty, counters 0.
- Reset mid-transfer aborts at once: the cycle is dropped and flits are lost. After release, req_ready=1 in the first cycle.
- Header flit is valid the cycle after the request handshake.
- noc_out_flit is stable while noc_out_valid=1 and noc_out_ready=0.
- wb_adr_o is stable while wb_stb_o=1 and no ack.
- Zero-wait-state ack gives 1 word/cycle in DATA. Per-packet overhead: 2 flit cycles.
- Initial read latency: the first data flit appears the cycle after the first ack.

## Configuration
- LISNOC_DMA_TARGET_WB_BURST_EN defined: wb_cti_o=3'b010 for every word of a packet except the last, which uses 3'b111.
- LISNOC_DMA_TARGET_WB_BURST_EN undefined: wb_cti_o=3'b000 (classic cycles) throughout.
- wb_cti_o=3'b000 whenever wb_stb_o=0.

## Structure
- Shared definitions go in lisnoc_def.vh / lisnoc_dma_def.vh:
  - flit type codes
  - PACKET_TYPE_R2L_RESP
  - PACKET_ID/PACKET_RESP_LAST/dest field positions
  - DEST_WIDTH
- One sub-module: the data FIFO, instantiated as lisnoc_fifo with depth 2.

## Test plan
- size 3, laddr 0x100, raddr 0x2000, dest 5, id 2, ack every cycle, ready=1 -> header(dest 5, id 2, RESP_LAST 1), 0x2000, then mem[0x100], mem[0x104], mem[0x108] with the last flit typed LAST. Burst build: cti 010,010,111.
- size 30 -> 3 packets with 14/14/2 data flits. Address flits 0x2000/0x2038/0x2070. RESP_LAST only on the third packet. busy falls after the final LAST flit.
- noc_out_ready low for 10 cycles mid-packet -> FIFO reaches 2 and stb drops. The stream resumes with no lost or duplicated words.
- ack delayed 3 cycles per word -> stb/cyc/adr held constant until ack. Flit order is correct.
- rst low during word 5 of a 14-word packet -> next cycle cyc/stb/valid are 0. A fresh size-1 request afterwards produces exactly 3 correct flits.
- size 0 -> header(RESP_LAST 1) plus an address flit typed LAST. No wb_cyc_o assertion.
